mux_logic_unit: RTL and testbench
=================================

MUX_LOGIC_UNIT -- requirements
Module: mux_logic_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the completed-operation counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand beat is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 The block SHALL have port op, input, 3 bits: the operation code, sampled with the beat.
REQ-008 The block SHALL have port a, input, WIDTH bits: operand A, used as the per-bit mux select.
REQ-009 The block SHALL have port b, input, WIDTH bits: operand B, used as the mux data source.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result beat is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-012 The block SHALL have port y, output, WIDTH bits: the result.
REQ-013 The block SHALL have port op_count, output, CNT_W bits: the number of results delivered, saturating.

Function
REQ-014 Each result bit i SHALL be produced by one 2:1 mux cell with sel=a[i], where y[i] = a[i] ? i1 : i0.
REQ-015 The mux data inputs (i0, i1) SHALL be selected by op as follows:
- 000 NAND: (1, ~b)
- 001 NOR: (~b, 0)
- 010 AND: (0, b)
- 011 OR: (b, 1)
- 100 XOR: (b, ~b)
- 101 XNOR: (~b, b)
- 110 NOT A: (1, 0)
- 111 PASS B: (b, b)
REQ-016 A beat SHALL be accepted when in_valid && in_ready is high at a rising clk edge.
REQ-017 A result SHALL be delivered when out_valid && out_ready is high at a rising clk edge.
REQ-018 The pipeline SHALL have two register stages:
- S1 registers op, a and b, with s1_valid.
- S2 registers the mux result into y, with s2_valid = out_valid.
REQ-019 Latency from input acceptance to out_valid SHALL be exactly 2 cycles when there is no backpressure.
REQ-020 The S2 advance condition SHALL be adv2 = !s2_valid || out_ready.
REQ-021 The S1 advance condition SHALL be adv1 = !s1_valid || adv2.
REQ-022 in_ready SHALL equal adv1, combinationally.
REQ-023 When adv2 is high, S2 SHALL load the S1 result and s2_valid SHALL load s1_valid.
REQ-024 When adv1 is high, S1 SHALL load the inputs and s1_valid SHALL load in_valid.
REQ-025 While a stage is stalled, its registers SHALL hold their contents unchanged.
REQ-026 Full throughput SHALL be one beat per cycle while out_ready is high.
REQ-027 With out_ready held low, the block SHALL hold at most two beats; in_ready SHALL fall only when both stages are valid.
REQ-028 When acceptance and delivery happen in the same cycle with both stages full, both stages SHALL shift with no bubble and no lost or duplicated beat.
REQ-029 Once out_valid is asserted, y SHALL remain stable until delivery.
REQ-030 op_count SHALL increment by 1 on each delivery and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-031 No X SHALL propagate to y or out_valid when in_valid is low.

Reset
REQ-032 Assertion of rst_n low SHALL asynchronously clear s1_valid, out_valid, y, the S1 registers and op_count to 0.
REQ-033 While in reset, in_ready SHALL be 1.
REQ-034 A reset asserted mid-operation SHALL discard all in-flight beats, and no result SHALL emerge after reset is released.
REQ-035 Deassertion of rst_n SHALL be synchronised externally; the first acceptance is permitted on the first rising edge with rst_n high.

Verification
REQ-036 Exhaustive single-bit check, WIDTH=1: all 8 ops × 4 (a,b) combinations -> y matches the table in REQ-015 (e.g. NAND a=1,b=1 -> 0).
REQ-037 Streaming check, WIDTH=8, out_ready=1: beats a=8'hF0, b=8'hCC with ops 000 to 111 on consecutive cycles -> y is, on consecutive cycles starting 2 cycles after the first beat: 3F, 03, C0, FC, 3C, C3, 0F, CC.
REQ-038 Backpressure check: out_ready=0 with 3 beats offered -> in_ready=0 after 2 accepted; on out_ready=1, results emerge in order with none lost; op_count=3.
REQ-039 Saturation check, CNT_W=4: deliver 20 beats -> op_count ends at 15.
REQ-040 Mid-reset check: pulse rst_n low while 2 beats are in flight -> out_valid=0, op_count=0 immediately; nothing emerges after release.
REQ-041 Random check: random valid/ready over 10k beats, WIDTH=13 -> scoreboard match, y stable while stalled.

Source files
------------

// File: rtl/mux_logic_unit_if.sv
`default_nettype none
// ============================================================================
// mux_logic_unit_if : operand / result handshake bundle for mux_logic_unit
// Revision 1.0
// ============================================================================
interface mux_logic_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, op_count
    );

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, op_count
    );
endinterface
`default_nettype wire

// File: rtl/mux_logic_unit.sv
`default_nettype none
// ============================================================================
// mux_logic_unit : two-stage pipelined logic unit built from per-bit 2:1 muxes
// Revision 1.0
// ============================================================================
module mux_logic_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mux_logic_unit_if.slave   bus
);
    localparam logic [2:0] OP_NAND = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;

    logic             s1_valid_q;
    logic [2:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] y_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_deliver;
    logic [WIDTH-1:0] w_i0;
    logic [WIDTH-1:0] w_i1;
    logic [WIDTH-1:0] y_d;

    assign w_adv2    = !s2_valid_q || bus.out_ready;
    assign w_adv1    = !s1_valid_q || w_adv2;
    assign w_deliver = s2_valid_q && bus.out_ready;

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = s2_valid_q;
    assign bus.y         = y_q;
    assign bus.op_count  = cnt_q;

    // Data inputs of every mux cell, chosen by the opcode held in S1.
    always_comb begin
        w_i0 = '0;
        w_i1 = '0;
        case (s1_op_q)
            OP_NAND: begin w_i0 = '1;      w_i1 = ~s1_b_q; end
            OP_NOR:  begin w_i0 = ~s1_b_q; w_i1 = '0;      end
            OP_AND:  begin w_i0 = '0;      w_i1 = s1_b_q;  end
            OP_OR:   begin w_i0 = s1_b_q;  w_i1 = '1;      end
            OP_XOR:  begin w_i0 = s1_b_q;  w_i1 = ~s1_b_q; end
            OP_XNOR: begin w_i0 = ~s1_b_q; w_i1 = s1_b_q;  end
            OP_NOTA: begin w_i0 = '1;      w_i1 = '0;      end
            default: begin w_i0 = s1_b_q;  w_i1 = s1_b_q;  end
        endcase
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign y_d[i] = s1_a_q[i] ? w_i1[i] : w_i0[i];
        end
    endgenerate

    assign cnt_d = (w_deliver && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

    // Data registers only capture qualified beats so idle X on a/b never reaches y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            cnt_q      <= '0;
        end else begin
            if (w_adv1) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_op_q <= bus.op;
                    s1_a_q  <= bus.a;
                    s1_b_q  <= bus.b;
                end
            end
            if (w_adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    y_q <= y_d;
                end
            end
            cnt_q <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mux_logic_unit.sv
`default_nettype none
// ============================================================================
// tb_mux_logic_unit : scoreboard bench over WIDTH=1, WIDTH=8 and WIDTH=13 units
// Revision 1.0
// ============================================================================
module tb_mux_logic_unit;
    logic clk;
    logic rst_n;

    mux_logic_unit_if #(.WIDTH(1),  .CNT_W(16)) bus1 ();
    mux_logic_unit_if #(.WIDTH(8),  .CNT_W(16)) bus8 ();
    mux_logic_unit_if #(.WIDTH(13), .CNT_W(4))  bus13 ();

    mux_logic_unit #(.WIDTH(1),  .CNT_W(16)) u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    mux_logic_unit #(.WIDTH(8),  .CNT_W(16)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    mux_logic_unit #(.WIDTH(13), .CNT_W(4))  u_dut13 (.clk(clk), .rst_n(rst_n), .bus(bus13.slave));

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] q1[$];
    logic [63:0] q8[$];
    logic [63:0] q13[$];
    int          cnt1_m, cnt8_m, cnt13_m;
    int          acc13;
    logic        hold8_v, hold13_v;
    logic [63:0] hold8_y, hold13_y;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: the logic function each opcode names, written as plain operators.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
        logic [63:0] r;
        logic [63:0] m;
        case (op)
            3'd0:    r = ~(a & b);
            3'd1:    r = ~(a | b);
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
            default: r = b;
        endcase
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return r & m;
    endfunction

    function automatic int sat_inc(input int c, input int cw);
        int top;
        top = (1 << cw) - 1;
        return (c >= top) ? top : c + 1;
    endfunction

    // Inputs change #1 after posedge, so the negedge view predicts the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete(); q8.delete(); q13.delete();
            cnt1_m = 0; cnt8_m = 0; cnt13_m = 0;
            hold8_v = 1'b0; hold13_v = 1'b0;
        end else begin
            if (bus1.out_valid && bus1.out_ready) begin
                if (q1.size() == 0) check("w1 unexpected result", 64'(bus1.out_valid), 64'd0);
                else                check("w1 y", 64'(bus1.y), q1.pop_front());
                check("w1 op_count", 64'(bus1.op_count), 64'(cnt1_m));
                cnt1_m = sat_inc(cnt1_m, 16);
            end
            if (bus1.in_valid && bus1.in_ready)
                q1.push_back(model(bus1.op, 64'(bus1.a), 64'(bus1.b), 1));

            if (hold8_v) begin
                check("w8 valid held", 64'(bus8.out_valid), 64'd1);
                check("w8 y stable", 64'(bus8.y), hold8_y);
            end
            hold8_v = bus8.out_valid && !bus8.out_ready;
            hold8_y = 64'(bus8.y);
            if (bus8.out_valid && bus8.out_ready) begin
                if (q8.size() == 0) check("w8 unexpected result", 64'(bus8.out_valid), 64'd0);
                else                check("w8 y", 64'(bus8.y), q8.pop_front());
                check("w8 op_count", 64'(bus8.op_count), 64'(cnt8_m));
                cnt8_m = sat_inc(cnt8_m, 16);
            end
            if (bus8.in_valid && bus8.in_ready)
                q8.push_back(model(bus8.op, 64'(bus8.a), 64'(bus8.b), 8));

            if (hold13_v) begin
                check("w13 valid held", 64'(bus13.out_valid), 64'd1);
                check("w13 y stable", 64'(bus13.y), hold13_y);
            end
            hold13_v = bus13.out_valid && !bus13.out_ready;
            hold13_y = 64'(bus13.y);
            if (bus13.out_valid && bus13.out_ready) begin
                if (q13.size() == 0) check("w13 unexpected result", 64'(bus13.out_valid), 64'd0);
                else                 check("w13 y", 64'(bus13.y), q13.pop_front());
                check("w13 op_count", 64'(bus13.op_count), 64'(cnt13_m));
                cnt13_m = sat_inc(cnt13_m, 4);
            end
            if (bus13.in_valid && bus13.in_ready) begin
                q13.push_back(model(bus13.op, 64'(bus13.a), 64'(bus13.b), 13));
                acc13++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] stream_exp [8];
    int         guard;

    initial begin
        stream_exp = '{8'h3F, 8'h03, 8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h0F, 8'hCC};
        acc13 = 0;
        rst_n = 1'b0;
        bus1.in_valid = 0;  bus1.op = 0;  bus1.a = 0;  bus1.b = 0;  bus1.out_ready = 1;
        bus8.in_valid = 0;  bus8.op = 0;  bus8.a = 0;  bus8.b = 0;  bus8.out_ready = 1;
        bus13.in_valid = 0; bus13.op = 0; bus13.a = 0; bus13.b = 0; bus13.out_ready = 1;
        repeat (3) tick();
        @(negedge clk);
        check("reset in_ready", 64'(bus8.in_ready), 64'd1);
        check("reset out_valid", 64'(bus8.out_valid), 64'd0);
        check("reset y", 64'(bus8.y), 64'd0);
        check("reset op_count", 64'(bus8.op_count), 64'd0);
        check("reset w13 out_valid", 64'(bus13.out_valid), 64'd0);
        tick();
        rst_n = 1'b1;

        // Exhaustive single-bit: every op against every (a,b) pair.
        for (int op = 0; op < 8; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                bus1.in_valid = 1'b1;
                bus1.op = 3'(op);
                bus1.a  = 1'(ab >> 1);
                bus1.b  = 1'(ab);
                tick();
            end
        end
        bus1.in_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("w1 exhaustive op_count", 64'(bus1.op_count), 64'd32);
        check("w1 drained", 64'(q1.size()), 64'd0);
        tick();

        // Streaming at full rate with the expected latency.
        for (int k = 0; k < 10; k++) begin
            bus8.in_valid = (k < 8);
            bus8.op = 3'(k);
            bus8.a  = 8'hF0;
            bus8.b  = 8'hCC;
            @(negedge clk);
            if (k < 2) begin
                check("stream latency idle", 64'(bus8.out_valid), 64'd0);
            end else begin
                check("stream out_valid", 64'(bus8.out_valid), 64'd1);
                check("stream y", 64'(bus8.y), 64'(stream_exp[k-2]));
            end
            tick();
        end
        bus8.in_valid = 1'b0;
        repeat (3) tick();

        // Backpressure: third beat must stall until the consumer drains.
        reset_pulse();
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1; bus8.op = 3'd3; bus8.a = 8'h5A; bus8.b = 8'h33; tick();
        bus8.op = 3'd4; bus8.a = 8'hA5; bus8.b = 8'h0F; tick();
        bus8.op = 3'd0; bus8.a = 8'hFF; bus8.b = 8'h81;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp in_ready low", 64'(bus8.in_ready), 64'd0);
            check("bp out_valid", 64'(bus8.out_valid), 64'd1);
            tick();
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        check("bp in_ready resumes", 64'(bus8.in_ready), 64'd1);
        tick();
        bus8.in_valid = 1'b0;
        guard = 0;
        while ((q8.size() != 0 || bus8.out_valid) && guard < 20) begin
            tick();
            guard++;
        end
        check("bp drain in time", 64'(guard < 20), 64'd1);
        @(negedge clk);
        check("bp op_count", 64'(bus8.op_count), 64'd3);
        tick();

        // Reset with two beats in flight discards them.
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1; bus8.op = 3'd2; bus8.a = 8'h12; bus8.b = 8'h34; tick();
        bus8.op = 3'd5; tick();
        bus8.in_valid = 1'b0;
        @(negedge clk);
        check("midrst in flight", 64'(bus8.out_valid), 64'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(bus8.out_valid), 64'd0);
        check("midrst op_count", 64'(bus8.op_count), 64'd0);
        check("midrst in_ready", 64'(bus8.in_ready), 64'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        bus8.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("midrst nothing emerges", 64'(bus8.out_valid), 64'd0);
            tick();
        end

        // Saturation of the 4-bit counter.
        for (int k = 0; k < 20; k++) begin
            bus13.in_valid = 1'b1;
            bus13.op = 3'($urandom_range(7, 0));
            bus13.a  = 13'($urandom);
            bus13.b  = 13'($urandom);
            tick();
        end
        bus13.in_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("sat op_count", 64'(bus13.op_count), 64'd15);
        tick();

        // Random valid/ready traffic.
        acc13 = 0;
        guard = 0;
        while (acc13 < 10000 && guard < 40000) begin
            bus13.in_valid  = ($urandom_range(3, 0) != 0);
            bus13.out_ready = ($urandom_range(2, 0) != 0);
            bus13.op = 3'($urandom_range(7, 0));
            bus13.a  = 13'($urandom);
            bus13.b  = 13'($urandom);
            tick();
            guard++;
        end
        check("random beats accepted", 64'(acc13 >= 10000), 64'd1);
        bus13.in_valid  = 1'b0;
        bus13.out_ready = 1'b1;
        guard = 0;
        while ((q13.size() != 0 || bus13.out_valid) && guard < 20) begin
            tick();
            guard++;
        end
        check("random drain", 64'(q13.size()), 64'd0);
        @(negedge clk);
        check("random op_count", 64'(bus13.op_count), 64'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
